// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus responder: register map, bus FSM states
// and the BCD increment helpers used by the timekeeping counter.
package rtc_pkg;

  localparam logic [7:0] ADDR_CTRL  = 8'h02;
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [7:0] ADDR_TSEC  = 8'h41;
  localparam logic [7:0] ADDR_TMIN  = 8'h42;
  localparam logic [7:0] ADDR_THOUR = 8'h43;

  localparam int CTRL_INIT_BIT = 2;

  localparam logic [7:0] DAY_RST   = 8'h01;
  localparam logic [7:0] MONTH_RST = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4
  } bus_state_e;

  // Out-of-range values (high nibble > 5, or hours past max) wrap to zero.
  function automatic logic bcd_wraps(input logic [7:0] v, input logic [7:0] max_v,
                                     input logic hour_mode);
    return (v == max_v) || (v[7:4] > 4'd5) || (hour_mode && (v > max_v));
  endfunction

  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max_v,
                                          input logic hour_mode);
    if (bcd_wraps(v, max_v, hour_mode))
      return 8'h00;
    else if (v[3:0] >= 4'd9)
      return {v[7:4] + 4'd1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/rtc_bus_responder_time.sv
// Seconds divider and BCD SEC/MIN/HOUR registers; bus writes override the
// incremented value of the written register while carries still propagate.
module bcd_time_counter
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_i,
  input  logic       sec_we_i,
  input  logic       min_we_i,
  input  logic       hour_we_i,
  input  logic [7:0] wdata_i,
  output logic       tick_o,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [7:0] hour_o
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic             sec_carry, min_carry;

  always_comb begin
    tick_o    = !init_i && (div_q == DIV_LAST);
    div_d     = (init_i || tick_o) ? '0 : div_q + DIV_W'(1);
    sec_carry = bcd_wraps(sec_q, 8'h59, 1'b0);
    min_carry = bcd_wraps(min_q, 8'h59, 1'b0);
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    if (tick_o) begin
      sec_d = bcd_next(sec_q, 8'h59, 1'b0);
      if (sec_carry) begin
        min_d = bcd_next(min_q, 8'h59, 1'b0);
        if (min_carry) hour_d = bcd_next(hour_q, 8'h23, 1'b1);
      end
    end
    if (sec_we_i)  sec_d  = wdata_i;
    if (min_we_i)  min_d  = wdata_i;
    if (hour_we_i) hour_d = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hour_q <= 8'h00;
    end else begin
      div_q  <= div_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  assign sec_o  = sec_q;
  assign min_o  = min_q;
  assign hour_o = hour_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// Multiplexed-AD RTC bus responder: synchronised strobe decode, address latch,
// register file and read-back path.
//   state    | meaning
//   IDLE     | chip not selected
//   SEL      | selected, waiting for a strobe
//   ADDR     | address strobe low, latch on wr_n rise
//   WDATA    | data write strobe low, commit on wr_n rise
//   RDATA    | read strobe low, driving the bus
module rtc_bus_responder
  import rtc_pkg::*;
#(
  parameter int TICK_DIV    = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       a_d,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic [7:0] addr_q,
  output logic       wr_pulse,
  output logic       tick,
  output logic       halted
);

  // Control vector order: {cs_n, a_d, rd_n, wr_n}
  localparam logic [3:0] CTL_IDLE = 4'b1011;

  logic [3:0] sync_q [SYNC_STAGES];
  logic [7:0] ad_pipe_q [SYNC_STAGES];
  logic [2:0] prev_q;
  logic       cs_s, ph_s, rd_s, wr_s;
  logic [7:0] ad_s;
  logic       cs_fall, cs_rise, rd_rise, wr_rise;

  bus_state_e state_q, state_d;
  logic       addr_commit, wr_commit, drive;
  logic       ad_oe_q, ad_oe_d;
  logic [7:0] ad_out_q, ad_out_d, rdata;

  logic [7:0] addr_lat_q, ctrl_q, day_q, month_q, year_q, tsec_q, tmin_q, thour_q;
  logic       ctrl_we, sec_we, min_we, hour_we, init_eff;
  logic [7:0] sec_v, min_v, hour_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i]    <= CTL_IDLE;
        ad_pipe_q[i] <= 8'h00;
      end
      prev_q <= 3'b111;
    end else begin
      sync_q[0]    <= {cs_n, a_d, rd_n, wr_n};
      ad_pipe_q[0] <= ad_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i]    <= sync_q[i-1];
        ad_pipe_q[i] <= ad_pipe_q[i-1];
      end
      prev_q <= {cs_s, rd_s, wr_s};
    end
  end

  assign {cs_s, ph_s, rd_s, wr_s} = sync_q[SYNC_STAGES-1];
  assign ad_s    = ad_pipe_q[SYNC_STAGES-1];
  assign cs_fall = prev_q[2] & ~cs_s;
  assign cs_rise = ~prev_q[2] & cs_s;
  assign rd_rise = ~prev_q[1] & rd_s;
  assign wr_rise = ~prev_q[0] & wr_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Write is checked before read so the bus is never driven while wr_n is low.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (cs_fall) state_d = ST_SEL;
        ST_SEL: begin
          if (!wr_s)             state_d = ph_s ? ST_WDATA : ST_ADDR;
          else if (!rd_s && ph_s) state_d = ST_RDATA;
        end
        ST_ADDR,
        ST_WDATA: if (wr_rise) state_d = ST_SEL;
        ST_RDATA: if (rd_rise) state_d = ST_SEL;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_commit = (state_q == ST_ADDR)  && wr_rise && !cs_rise;
    wr_commit   = (state_q == ST_WDATA) && wr_rise && !cs_rise;
    drive       = (state_q == ST_RDATA) && !rd_rise && !cs_rise && wr_s;
    ad_oe_d     = drive;
    ad_out_d    = drive ? rdata : 8'h00;
  end

  always_comb begin
    ctrl_we  = wr_commit && (addr_lat_q == ADDR_CTRL);
    sec_we   = wr_commit && (addr_lat_q == ADDR_SEC);
    min_we   = wr_commit && (addr_lat_q == ADDR_MIN);
    hour_we  = wr_commit && (addr_lat_q == ADDR_HOUR);
    init_eff = ctrl_q[CTRL_INIT_BIT] | (ctrl_we & ad_s[CTRL_INIT_BIT]);
  end

  always_comb begin
    rdata = 8'h00;
    case (addr_lat_q)
      ADDR_CTRL:  rdata = ctrl_q;
      ADDR_SEC:   rdata = sec_v;
      ADDR_MIN:   rdata = min_v;
      ADDR_HOUR:  rdata = hour_v;
      ADDR_DAY:   rdata = day_q;
      ADDR_MONTH: rdata = month_q;
      ADDR_YEAR:  rdata = year_q;
      ADDR_TSEC:  rdata = tsec_q;
      ADDR_TMIN:  rdata = tmin_q;
      ADDR_THOUR: rdata = thour_q;
      default:    rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_lat_q <= 8'h00;
      ctrl_q     <= 8'h00;
      day_q      <= DAY_RST;
      month_q    <= MONTH_RST;
      year_q     <= 8'h00;
      tsec_q     <= 8'h00;
      tmin_q     <= 8'h00;
      thour_q    <= 8'h00;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= 8'h00;
    end else begin
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
      if (addr_commit) addr_lat_q <= ad_s;
      if (wr_commit) begin
        case (addr_lat_q)
          ADDR_CTRL:  ctrl_q  <= ad_s;
          ADDR_DAY:   day_q   <= ad_s;
          ADDR_MONTH: month_q <= ad_s;
          ADDR_YEAR:  year_q  <= ad_s;
          ADDR_TSEC:  tsec_q  <= ad_s;
          ADDR_TMIN:  tmin_q  <= ad_s;
          ADDR_THOUR: thour_q <= ad_s;
          default:    ;
        endcase
      end
    end
  end

  bcd_time_counter #(.TICK_DIV(TICK_DIV)) u_time (
    .clk       (clk),
    .rst_n     (reset),
    .init_i    (init_eff),
    .sec_we_i  (sec_we),
    .min_we_i  (min_we),
    .hour_we_i (hour_we),
    .wdata_i   (ad_s),
    .tick_o    (tick),
    .sec_o     (sec_v),
    .min_o     (min_v),
    .hour_o    (hour_v)
  );

  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign addr_q   = addr_lat_q;
  assign wr_pulse = wr_commit;
  assign halted   = ctrl_q[CTRL_INIT_BIT];

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: table vectors, randomized register traffic
// against a map model, and wall-clock timekeeping checks.
module tb_rtc_bus_responder;
  import rtc_pkg::*;

  localparam int TDIV = 8;
  localparam int SS   = 2;
  localparam int L    = SS + 1;   // drive edge to internal action, in clocks
  localparam int NV   = 14;

  logic       clk = 1'b0, reset = 1'b0;
  logic       cs_n = 1'b1, a_d = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0] ad_in = 8'h00;
  logic [7:0] ad_out, addr_q;
  logic       ad_oe, wr_pulse, tick, halted;

  rtc_bus_responder #(.TICK_DIV(TDIV), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .a_d(a_d), .rd_n(rd_n), .wr_n(wr_n),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .addr_q(addr_q),
    .wr_pulse(wr_pulse), .tick(tick), .halted(halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_pulse === 1'b1) pulses <= pulses + 1;

  int tests = 0, fails = 0;

  // Wall-clock model: run started at edge E, stopped at edge H.
  int E = 0, H = 32'h3fff_ffff, base_s = 0;

  logic [7:0] mdl [256];

  typedef struct {
    logic [7:0] addr;
    bit         wr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit mapped(input logic [7:0] a);
    return a == ADDR_CTRL || (a >= 8'h21 && a <= 8'h26) || (a >= 8'h41 && a <= 8'h43);
  endfunction

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [7:0] exp_time(input int ek, input int sel);
    int n, cap, s;
    n = (ek > E) ? (ek - E) / TDIV : 0;
    if (H > E) begin
      cap = (H - E - 1) / TDIV;
      if (n > cap) n = cap;
    end
    s = (base_s + n) % 86400;
    case (sel)
      0:       return bcd(s % 60);
      1:       return bcd((s / 60) % 60);
      default: return bcd(s / 3600);
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_begin();
    cs_n = 1'b0; step(L + 2);
  endtask

  task automatic cs_end();
    cs_n = 1'b1; step(L + 2);
  endtask

  task automatic addr_ph(input logic [7:0] a);
    a_d = 1'b0; ad_in = a; step(1);
    wr_n = 1'b0; step(L + 2);
    wr_n = 1'b1; step(L + 2);
  endtask

  task automatic data_wr(input logic [7:0] d, output int rise_edge);
    a_d = 1'b1; ad_in = d; step(1);
    wr_n = 1'b0; step(L + 2);
    wr_n = 1'b1; rise_edge = cyc; step(L + 2);
  endtask

  task automatic rd_open();
    a_d = 1'b1; step(1);
    rd_n = 1'b0; step(L + 1);
  endtask

  task automatic rd_close(input string name);
    rd_n = 1'b1; step(L + 1);
    @(negedge clk);
    chk({name, " oe release"}, ad_oe, 0);
    step(1);
  endtask

  task automatic do_read(input logic [7:0] exp, input string name);
    rd_open();
    @(negedge clk);
    chk({name, " oe"}, ad_oe, 1);
    chk(name, ad_out, exp);
    rd_close(name);
  endtask

  task automatic read_time(input logic [7:0] a, input int sel, input string name);
    addr_ph(a);
    rd_open();
    @(negedge clk);
    chk({name, " oe"}, ad_oe, 1);
    chk(name, ad_out, exp_time(cyc - 1, sel));
    rd_close(name);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    int r;
    addr_ph(a);
    data_wr(d, r);
  endtask

  // Load a time while halted, run for exactly one tick, then halt again.
  task automatic one_tick(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                          input logic [7:0] es, input logic [7:0] em, input logic [7:0] eh,
                          input string name);
    int r0, r1;
    wr_reg(ADDR_SEC, s);
    wr_reg(ADDR_MIN, m);
    wr_reg(ADDR_HOUR, h);
    addr_ph(ADDR_CTRL);
    data_wr(8'h00, r0);
    data_wr(8'h04, r1);
    chk({name, " halted"}, halted, 1);
    addr_ph(ADDR_SEC);  do_read(es, {name, " sec"});
    addr_ph(ADDR_MIN);  do_read(em, {name, " min"});
    addr_ph(ADDR_HOUR); do_read(eh, {name, " hour"});
  endtask

  logic [7:0] pool [14];

  initial begin
    int p0, r, nr, nh, k;
    logic [7:0] a, d;

    vt[0]  = '{ADDR_CTRL,  1'b1, 8'h04, 8'h00};
    vt[1]  = '{ADDR_CTRL,  1'b0, 8'h00, 8'h04};
    vt[2]  = '{ADDR_DAY,   1'b0, 8'h00, 8'h01};
    vt[3]  = '{ADDR_MONTH, 1'b0, 8'h00, 8'h01};
    vt[4]  = '{ADDR_YEAR,  1'b0, 8'h00, 8'h00};
    vt[5]  = '{ADDR_MIN,   1'b0, 8'h00, 8'h00};
    vt[6]  = '{8'h30,      1'b1, 8'hAA, 8'h00};
    vt[7]  = '{8'h30,      1'b0, 8'h00, 8'h00};
    vt[8]  = '{ADDR_TSEC,  1'b1, 8'h37, 8'h00};
    vt[9]  = '{ADDR_TSEC,  1'b0, 8'h00, 8'h37};
    vt[10] = '{ADDR_CTRL,  1'b1, 8'hFF, 8'h00};
    vt[11] = '{ADDR_CTRL,  1'b0, 8'h00, 8'hFF};
    vt[12] = '{ADDR_HOUR,  1'b1, 8'h1A, 8'h00};
    vt[13] = '{ADDR_HOUR,  1'b0, 8'h00, 8'h1A};

    pool = '{8'h02, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
             8'h41, 8'h42, 8'h43, 8'h30, 8'h00, 8'h44, 8'hFF};

    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    mdl[ADDR_DAY]   = 8'h01;
    mdl[ADDR_MONTH] = 8'h01;

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst ad_out", ad_out, 0);
    chk("rst ad_oe", ad_oe, 0);
    chk("rst addr_q", addr_q, 0);
    chk("rst wr_pulse", wr_pulse, 0);
    chk("rst tick", tick, 0);
    chk("rst halted", halted, 0);
    reset = 1'b1;
    step(2);

    // Table vectors
    for (int i = 0; i < NV; i++) begin
      cs_begin();
      p0 = pulses;
      addr_ph(vt[i].addr);
      chk("tbl addr_q", addr_q, vt[i].addr);
      if (vt[i].wr) begin
        data_wr(vt[i].data, r);
        chk("tbl wr_pulse count", pulses - p0, 1);
        if (mapped(vt[i].addr)) mdl[vt[i].addr] = vt[i].data;
      end else begin
        do_read(vt[i].exp, "tbl read");
      end
      chk("tbl halted", halted, mdl[ADDR_CTRL][CTRL_INIT_BIT]);
      cs_end();
    end

    // Random register traffic while halted
    for (int i = 0; i < 20; i++) begin
      a = pool[$urandom_range(0, 13)];
      d = 8'($urandom);
      if (a == ADDR_CTRL) d[CTRL_INIT_BIT] = 1'b1;
      cs_begin();
      p0 = pulses;
      addr_ph(a);
      data_wr(d, r);
      chk("rnd wr_pulse count", pulses - p0, 1);
      if (mapped(a)) mdl[a] = d;
      do_read(mapped(a) ? mdl[a] : 8'h00, "rnd readback");
      do_read(mapped(a) ? mdl[a] : 8'h00, "rnd addr hold");
      cs_end();
    end

    // Release INIT and watch SEC count through a minute rollover
    cs_begin();
    wr_reg(ADDR_SEC, 8'h56);
    wr_reg(ADDR_MIN, 8'h10);
    wr_reg(ADDR_HOUR, 8'h05);
    addr_ph(ADDR_CTRL);
    base_s = 5 * 3600 + 10 * 60 + 56;
    H = 32'h3fff_ffff;
    data_wr(8'h00, nr);
    E = nr + L;
    chk("release halted", halted, 0);
    addr_ph(ADDR_SEC);
    rd_open();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      k = cyc;
      chk("watch sec", ad_out, exp_time(k - 1, 0));
      chk("watch tick", tick, ((k - E) % TDIV == TDIV - 1) ? 1 : 0);
      step(1);
    end
    rd_close("watch");
    read_time(ADDR_MIN, 1, "run min");
    read_time(ADDR_HOUR, 2, "run hour");
    addr_ph(ADDR_CTRL);
    do_read(8'h00, "ctrl after release");
    data_wr(8'h04, nh);
    H = nh + L;
    chk("halt halted", halted, 1);
    read_time(ADDR_SEC, 0, "frozen sec");
    read_time(ADDR_MIN, 1, "frozen min");

    // Single-tick boundary cases
    one_tick(8'h59, 8'h59, 8'h23, 8'h00, 8'h00, 8'h00, "day wrap");
    one_tick(8'h75, 8'h20, 8'h30, 8'h00, 8'h21, 8'h30, "bad sec");
    one_tick(8'h59, 8'h59, 8'h24, 8'h00, 8'h00, 8'h00, "bad hour");
    one_tick(8'h09, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, "nibble carry");
    cs_end();

    // Reset in the middle of a data write
    cs_begin();
    addr_ph(ADDR_MIN);
    a_d = 1'b1; ad_in = 8'h12; step(1);
    wr_n = 1'b0; step(L + 2);
    reset = 1'b0;
    step(2);
    @(negedge clk);
    chk("midrst ad_oe", ad_oe, 0);
    chk("midrst addr_q", addr_q, 0);
    chk("midrst halted", halted, 0);
    chk("midrst fsm", dut.state_q, ST_IDLE);
    wr_n = 1'b1; cs_n = 1'b1; a_d = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    cs_begin();
    addr_ph(ADDR_MIN);
    do_read(8'h00, "midrst min");
    p0 = pulses;
    data_wr(8'h12, r);
    chk("post wr_pulse count", pulses - p0, 1);
    do_read(8'h12, "post min");
    cs_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Responder end of the multiplexed-AD real-time-clock bus; the existing RTC bus controller drives this bus as the initiator.
- Decodes cs_n / a_d / rd_n / wr_n strobes on an 8-bit multiplexed address/data bus, latches the address, and writes or reads an internal RTC register file.
- Keeps BCD time (seconds/minutes/hours) running from a divided tick.
- Used as the on-chip RTC model for system simulation and as a standalone RTC target.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick (minimum 4).
- SYNC_STAGES, 2, synchroniser depth on the bus control inputs (minimum 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cs_n  in  1  chip select, active low.
- a_d  in  1  0 = address phase, 1 = data phase.
- rd_n  in  1  read strobe, active low.
- wr_n  in  1  write strobe, active low.
- ad_in  in  8  multiplexed address/data from the initiator.
- ad_out  out  8  read data.
- ad_oe  out  1  1 = responder drives the bus (tri-state enable at top level).
- addr_q  out  8  currently latched register address.
- wr_pulse  out  1  one-cycle pulse on each committed data write.
- tick  out  1  one-cycle pulse per second.
- halted  out  1  mirrors CTRL.INIT.

Behaviour:
- Reset (reset=0, async):
  - ad_out=0x00, ad_oe=0, addr_q=0x00, wr_pulse=0, tick=0, divider=0, FSM=IDLE.
  - CTRL=0x00, SEC/MIN/HOUR/YEAR=0x00, DAY/MONTH=0x01, TSEC/TMIN/THOUR=0x00.
- Input capture:
  - cs_n, a_d, rd_n and wr_n pass through SYNC_STAGES flops.
  - ad_in is sampled alongside the last synchroniser stage.
  - Strobe edges are detected on the synchronised signals.
- Register map (all others: writes ignored, reads 0x00):
  - 0x02 CTRL; bit2 = INIT, other bits read back as written.
  - 0x21 SEC, 0x22 MIN, 0x23 HOUR, 0x24 DAY, 0x25 MONTH, 0x26 YEAR.
  - 0x41 TSEC, 0x42 TMIN, 0x43 THOUR (plain storage).
- FSM states: IDLE, SEL, ADDR, WDATA, RDATA.
  - IDLE: cs_n=1. Go to SEL when cs_n falls.
  - SEL: if a_d=0 and wr_n=0, go to ADDR. If a_d=1 and wr_n=0, go to WDATA. If a_d=1 and rd_n=0, go to RDATA.
  - ADDR: on wr_n rising edge, addr_q <= sampled ad_in, then go to SEL.
  - WDATA: on wr_n rising edge, reg[addr_q] <= sampled ad_in, wr_pulse=1 for that cycle, then go to SEL.
  - RDATA: ad_oe=1 and ad_out=reg[addr_q], registered 1 cycle after entry. On rd_n rising edge, ad_oe=0 and go to SEL.
  - cs_n rising from any state: go to IDLE, ad_oe=0 next cycle, and abort any uncommitted write (no register change).
  - rd_n and wr_n both low in SEL: write takes priority; never drive the bus while wr_n is low.
  - a_d changing mid-strobe: the phase is taken from a_d at the strobe falling edge.
- Address latch: addr_q holds across transactions. Several data writes without a new address phase all go to the same address.
- Timekeeping:
  - The divider counts 0..TICK_DIV-1; tick pulses at the wrap.
  - While CTRL.INIT=1: divider held at 0, no ticks, time registers frozen.
  - Writing CTRL with INIT=1 clears the divider in the same cycle.
- BCD increment on tick:
  - SEC: 0x59 -> 0x00 with carry to MIN. Otherwise, low nibble >= 9 -> 0 and high nibble +1; else low nibble +1.
  - MIN: same rule as SEC, carry to HOUR.
  - HOUR: 0x23 -> 0x00, no further carry.
  - Non-BCD written values are stored as-is. An increment from an out-of-range value (high nibble > 5, or HOUR > 0x23) goes to 0x00 with carry.
- Simultaneous events:
  - Bus write to SEC/MIN/HOUR in the same cycle as tick: the bus value wins for that register. Carries into other registers still apply.
  - Read of a time register in the same cycle as tick: returns the pre-increment value, then the post-increment value next cycle while RDATA persists.

Decomposition:
- Package rtc_pkg:
  - Register address constants (ADDR_CTRL=0x02, ADDR_SEC=0x21 … ADDR_THOUR=0x43).
  - CTRL_INIT_BIT=2.
  - FSM state enum.
  - Reset values for DAY/MONTH.
- Sub-module bcd_time_counter: divider, tick, SEC/MIN/HOUR BCD increment with carry, write-override inputs. The responder owns the bus FSM and register file.

Test Plan:
- Init sequence: address 0x02 / data 0x04, then address 0x02 / data 0x00 -> halted goes 1 then 0; CTRL reads 0x00; divider restarted.
- Write address 0x21 then data 0x58, TICK_DIV=8, INIT=0 -> SEC=0x59 after 8 clk, then SEC=0x00 and MIN +1 after 16 clk.
- Set HOUR=0x23, MIN=0x59, SEC=0x59 and run one tick -> all three read 0x00.
- Address 0x24 then read strobe -> ad_oe=1 with ad_out=0x01 within 1 cycle of synchronised rd_n low; ad_oe=0 after rd_n rises.
- Write data 0xAA to unmapped address 0x30, then read it back -> ad_out=0x00; wr_pulse still pulses once.
- Assert reset mid-WDATA (wr_n low, data 0x12 to 0x22) -> MIN=0x00, ad_oe=0, FSM=IDLE; the subsequent transaction completes normally.
